usr_seq: RTL

USR_SEQ -- requirements
Module: usr_seq

---
 rtl/usr_pkg.sv | 30 +++
 rtl/usr_d.sv | 38 +++
 rtl/usr_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// usr_pkg : op codes, register mode codes and FSM encoding for usr_seq
// Rev 1.0
// ============================================================================
package usr_pkg;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'b00,
      OP_ROT     = 2'b01,
      OP_SHIFT   = 2'b10,
      OP_LOADROT = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_ROT   = 2'b01,
      MODE_SHIFT = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

endpackage
`default_nettype wire

// File: rtl/usr_d.sv
`default_nettype none
// ============================================================================
// usr_d : 4-bit universal shift register (hold / rotate-left / shift-left / load)
// Rev 1.0
// ============================================================================
module usr_d
   import usr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] s,
   input  logic [3:0] a,
   input  logic       rs,
   input  logic       ls,
   output logic [3:0] q
);
   logic [3:0] r_q;
   logic       w_unused_ls;

   // Left shifts only, so the high-end fill has no destination here.
   assign w_unused_ls = ls;
   assign q           = r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 4'd0;
      end else begin
         case (mode_t'(s))
            MODE_ROT:   r_q <= {r_q[2:0], r_q[3]};
            MODE_SHIFT: r_q <= {r_q[2:0], rs};
            MODE_LOAD:  r_q <= a;
            default:    r_q <= r_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/usr_seq.sv
`default_nettype none
// ============================================================================
// usr_seq : command sequencer driving a 4-bit universal shift register
// Rev 1.0
// ============================================================================
module usr_seq
   import usr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_data,
   input  logic [2:0] cmd_cnt,
   output logic [1:0] s,
   output logic [3:0] a,
   output logic       rs,
   output logic       ls,
   input  logic [3:0] q_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] res
);
   state_t     r_state;
   state_t     w_next;
   op_t        r_op;
   logic [3:0] r_data;
   logic [2:0] r_cnt;
   logic [2:0] r_step;
   logic [3:0] r_res;
   logic       w_accept;
   op_t        w_op;

   assign cmd_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_op      = op_t'(cmd_op);
   assign res       = r_res;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_op == OP_LOAD || w_op == OP_LOADROT) w_next = ST_LOAD;
               else if (cmd_cnt != 3'd0)                 w_next = ST_RUN;
               else                                      w_next = ST_DONE;
            end
         end
         ST_LOAD: w_next = (r_op == OP_LOADROT && r_cnt != 3'd0) ? ST_RUN : ST_DONE;
         // Exit on the last step so cnt=7 runs exactly seven cycles.
         ST_RUN:  if (r_step <= 3'd1) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      s    = MODE_HOLD;
      a    = 4'd0;
      rs   = 1'b0;
      ls   = 1'b0;
      busy = 1'b1;
      done = 1'b0;
      case (r_state)
         ST_IDLE: busy = 1'b0;
         ST_LOAD: begin
            s = MODE_LOAD;
            a = r_data;
         end
         ST_RUN: begin
            if (r_op == OP_SHIFT) begin
               s  = MODE_SHIFT;
               rs = r_data[0];
               ls = r_data[3];
            end else begin
               s  = MODE_ROT;
            end
         end
         ST_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_LOAD;
         r_data  <= 4'd0;
         r_cnt   <= 3'd0;
         r_step  <= 3'd0;
         r_res   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op   <= w_op;
            r_data <= cmd_data;
            r_cnt  <= cmd_cnt;
            r_step <= cmd_cnt;
         end else if (r_state == ST_RUN) begin
            r_step <= r_step - 3'd1;
         end
         if (r_state == ST_DONE) r_res <= q_in;
      end
   end

endmodule
`default_nettype wire
